fetch_redirect_unit: RTL and testbench

- Owns the program counter and the instruction fetch handshake for the 16-bit RISC pipeline.
- Consumes the EX-stage redirect decisions (is_taken for BEQ, is_jlr for JLR) and steers the PC to the branch or JLR target.
- Squashes the two younger in-flight instructions on every redirect.
- Feeds the IF/ID register with instr, pc_out and instr_valid.

---
 rtl/rv16_pkg.sv | 18 +
 rtl/next_pc_sel.sv | 35 +++
 rtl/fetch_redirect_unit.sv | 154 +++++++++++++++
 tb/tb_fetch_redirect_unit.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv16_pkg.sv
// Shared definitions for the 16-bit RISC pipeline front end.
package rv16_pkg;

  localparam int XLEN = 16;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 16'h0000;

  // Opcodes that produce redirects; also used by branch control.
  localparam logic [3:0] OP_JLR = 4'b1001;
  localparam logic [3:0] OP_BEQ = 4'b1100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DROP  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC mux. The redirect target beats the parked pending target,
// which beats the sequential increment. With no select asserted, pc holds.
module next_pc_sel
  import rv16_pkg::*;
#(
  parameter logic [XLEN-1:0] PC_INC = 16'd1
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] br_target_i,
  input  logic [XLEN-1:0] jlr_target_i,
  input  logic [XLEN-1:0] pending_i,
  input  logic            is_jlr_i,
  input  logic            sel_target_i,
  input  logic            sel_pending_i,
  input  logic            sel_inc_i,
  output logic [XLEN-1:0] target_o,
  output logic [XLEN-1:0] next_pc_o
);

  // JLR target wins when both branch kinds are flagged.
  assign target_o = is_jlr_i ? jlr_target_i : br_target_i;

  // Priority select of the next PC; the add wraps naturally at 16 bits.
  always_comb begin
    next_pc_o = pc_i;
    if (sel_target_i) begin
      next_pc_o = target_o;
    end else if (sel_pending_i) begin
      next_pc_o = pending_i;
    end else if (sel_inc_i) begin
      next_pc_o = pc_i + PC_INC;
    end
  end

endmodule

// File: rtl/fetch_redirect_unit.sv
// Program counter, instruction fetch handshake and redirect/squash control.
//
// state | meaning
// IDLE  | first cycle out of reset, no request issued
// FETCH | requesting imem at pc, capturing into IF/ID on transfer
// DROP  | redirected while a request was outstanding; finish it, discard
//       | the data, then resume at the parked target
module fetch_redirect_unit
  import rv16_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [XLEN-1:0] PC_INC   = 16'd1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic            is_taken,
  input  logic            is_jlr,
  input  logic [XLEN-1:0] br_target,
  input  logic [XLEN-1:0] jlr_target,
  input  logic            stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc_out,
  output logic            instr_valid,
  output logic            flush_ifid,
  output logic            flush_idex
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pending_q, pending_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_out_q, pc_out_d;
  logic            valid_q, valid_d;
  logic            flush_q, flush_d;

  logic            redirect;
  logic            xfer;
  logic [XLEN-1:0] target;
  logic            sel_target, sel_pending, sel_inc;

  assign redirect = ex_valid & (is_taken | is_jlr);
  assign xfer     = imem_req & imem_ready;

  next_pc_sel #(.PC_INC(PC_INC)) u_next_pc_sel (
    .pc_i          (pc_q),
    .br_target_i   (br_target),
    .jlr_target_i  (jlr_target),
    .pending_i     (pending_q),
    .is_jlr_i      (is_jlr),
    .sel_target_i  (sel_target),
    .sel_pending_i (sel_pending),
    .sel_inc_i     (sel_inc),
    .target_o      (target),
    .next_pc_o     (pc_d)
  );

  // State register and IF/ID-facing registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      pending_q <= '0;
      instr_q   <= '0;
      pc_out_q  <= RESET_PC;
      valid_q   <= 1'b0;
      flush_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pending_q <= pending_d;
      instr_q   <= instr_d;
      pc_out_q  <= pc_out_d;
      valid_q   <= valid_d;
      flush_q   <= flush_d;
    end
  end

  // Next-state: transfers, stalls and redirects (redirect beats stall).
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    instr_d     = instr_q;
    pc_out_d    = pc_out_q;
    valid_d     = valid_q;
    flush_d     = 1'b0;
    sel_target  = 1'b0;
    sel_pending = 1'b0;
    sel_inc     = 1'b0;
    case (state_q)
      IDLE: begin
        state_d    = FETCH;
        sel_target = redirect;
      end
      FETCH: begin
        if (redirect) begin
          flush_d = 1'b1;
          valid_d = 1'b0;
          // Outstanding request must complete at its old address first.
          if (imem_req && !imem_ready) begin
            pending_d = target;
            state_d   = DROP;
          end else begin
            sel_target = 1'b1;
          end
        end else if (xfer) begin
          instr_d  = imem_rdata;
          pc_out_d = pc_q;
          valid_d  = 1'b1;
          sel_inc  = 1'b1;
        end else if (!(stall && valid_q)) begin
          valid_d = 1'b0;
        end
      end
      DROP: begin
        valid_d = 1'b0;
        if (redirect) begin
          flush_d   = 1'b1;
          pending_d = target;
        end
        if (imem_ready) begin
          state_d = FETCH;
          if (redirect) begin
            sel_target = 1'b1;
          end else begin
            sel_pending = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: request gating and registered IF/ID values.
  always_comb begin
    imem_req = 1'b0;
    case (state_q)
      FETCH:   imem_req = !(stall && valid_q);
      DROP:    imem_req = 1'b1;
      default: imem_req = 1'b0;
    endcase
    imem_addr   = pc_q;
    instr       = instr_q;
    pc_out      = pc_out_q;
    instr_valid = valid_q;
    flush_ifid  = flush_q;
    flush_idex  = flush_q;
  end

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Self-checking bench for fetch_redirect_unit. The memory model returns
// addr ^ A5A5; a scoreboard holds the PCs expected to reach IF/ID in order.
`timescale 1ns/1ps
module tb_fetch_redirect_unit;

  logic        clk = 1'b0;
  logic        rst_n, ex_valid, is_taken, is_jlr, stall, imem_ready;
  logic [15:0] br_target, jlr_target, imem_rdata, imem_addr, instr, pc_out;
  logic        imem_req, instr_valid, flush_ifid, flush_idex;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_q[$];
  logic        hold_prev = 1'b0;

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr ^ 16'hA5A5;

  fetch_redirect_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ex_valid   (ex_valid),
    .is_taken   (is_taken),
    .is_jlr     (is_jlr),
    .br_target  (br_target),
    .jlr_target (jlr_target),
    .stall      (stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .pc_out     (pc_out),
    .instr_valid(instr_valid),
    .flush_ifid (flush_ifid),
    .flush_idex (flush_idex)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect_beq(input logic [15:0] t);
    ex_valid  = 1'b1;
    is_taken  = 1'b1;
    br_target = t;
  endtask

  task automatic clr_redirect();
    ex_valid = 1'b0;
    is_taken = 1'b0;
    is_jlr   = 1'b0;
  endtask

  // Memory ready for n cycles starting with the DUT fetching at start.
  task automatic run_seq(input int n, input logic [15:0] start);
    logic [15:0] a;
    a = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(a);
      a = a + 16'd1;
    end
    imem_ready = 1'b1;
    for (int i = 0; i < n; i++) step();
    imem_ready = 1'b0;
  endtask

  // Scoreboard: each new IF/ID entry pops one expected PC.
  always @(negedge clk) begin
    logic [15:0] e;
    if (!rst_n) begin
      hold_prev = 1'b0;
    end else begin
      if (instr_valid === 1'b1 && !hold_prev) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", {15'd0, instr_valid}, 16'd0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_pc_out", pc_out, e);
          chk("sb_instr", instr, e ^ 16'hA5A5);
        end
      end
      hold_prev = stall && (instr_valid === 1'b1) && !(ex_valid && (is_taken || is_jlr));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ex_valid = 1'b0; is_taken = 1'b0; is_jlr = 1'b0; stall = 1'b0;
    imem_ready = 1'b1; br_target = '0; jlr_target = '0;
    step(); step();
    chk("rst_req", {15'd0, imem_req}, 16'd0);
    chk("rst_valid", {15'd0, instr_valid}, 16'd0);
    chk("rst_flush_ifid", {15'd0, flush_ifid}, 16'd0);
    chk("rst_flush_idex", {15'd0, flush_idex}, 16'd0);
    chk("rst_pc_out", pc_out, 16'h0000);
    chk("rst_instr", instr, 16'h0000);

    // Sequential fetch out of reset.
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(16'(i));
    step();
    chk("first_edge_valid", {15'd0, instr_valid}, 16'd0);
    chk("first_req", {15'd0, imem_req}, 16'd1);
    chk("first_addr", imem_addr, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("seq_req", {15'd0, imem_req}, 16'd1);
    end
    imem_ready = 1'b0;

    // BEQ redirect at pc=5.
    run_seq(1, 16'h0004);
    redirect_beq(16'h0040);
    imem_ready = 1'b1;
    #1 chk("beq_pre_addr", imem_addr, 16'h0005);
    step();
    clr_redirect();
    imem_ready = 1'b0;
    chk("beq_addr", imem_addr, 16'h0040);
    chk("beq_flush_ifid", {15'd0, flush_ifid}, 16'd1);
    chk("beq_flush_idex", {15'd0, flush_idex}, 16'd1);
    chk("beq_valid", {15'd0, instr_valid}, 16'd0);
    step();
    chk("beq_flush_ifid_end", {15'd0, flush_ifid}, 16'd0);
    chk("beq_flush_idex_end", {15'd0, flush_idex}, 16'd0);
    run_seq(2, 16'h0040);

    // JLR beats BEQ.
    ex_valid = 1'b1; is_jlr = 1'b1; is_taken = 1'b1;
    jlr_target = 16'h1234; br_target = 16'h0040;
    imem_ready = 1'b1;
    step();
    clr_redirect();
    imem_ready = 1'b0;
    chk("jlr_addr", imem_addr, 16'h1234);
    chk("jlr_flush", {15'd0, flush_ifid}, 16'd1);
    run_seq(1, 16'h1234);

    // Same request without ex_valid: plain fetch, no flush.
    ex_valid = 1'b0; is_jlr = 1'b1; is_taken = 1'b1;
    imem_ready = 1'b1;
    exp_q.push_back(16'h1235);
    step();
    clr_redirect();
    imem_ready = 1'b0;
    chk("gated_flush_ifid", {15'd0, flush_ifid}, 16'd0);
    chk("gated_flush_idex", {15'd0, flush_idex}, 16'd0);
    chk("gated_addr", imem_addr, 16'h1236);

    // Redirects while a request at 0010 waits.
    redirect_beq(16'h0010);
    imem_ready = 1'b1;
    step();
    clr_redirect();
    imem_ready = 1'b0;
    chk("wait_start_addr", imem_addr, 16'h0010);
    redirect_beq(16'h0080);
    #1 chk("w1_req", {15'd0, imem_req}, 16'd1);
    step();
    redirect_beq(16'h0090);
    chk("w2_addr", imem_addr, 16'h0010);
    chk("w2_flush", {15'd0, flush_ifid}, 16'd1);
    step();
    clr_redirect();
    chk("w3_addr", imem_addr, 16'h0010);
    chk("w3_flush", {15'd0, flush_idex}, 16'd1);
    chk("w3_req", {15'd0, imem_req}, 16'd1);
    step();
    chk("w4_flush", {15'd0, flush_ifid}, 16'd0);
    chk("w4_addr", imem_addr, 16'h0010);
    chk("w4_valid", {15'd0, instr_valid}, 16'd0);
    imem_ready = 1'b1;
    step();
    chk("w_resume_addr", imem_addr, 16'h0090);
    chk("w_resume_valid", {15'd0, instr_valid}, 16'd0);
    exp_q.push_back(16'h0090);
    step();
    imem_ready = 1'b0;

    // Stall holds IF/ID, then a redirect during the stall wins.
    run_seq(1, 16'h0091);
    stall = 1'b1;
    imem_ready = 1'b1;
    #1 chk("stall_req", {15'd0, imem_req}, 16'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("stall_valid", {15'd0, instr_valid}, 16'd1);
      chk("stall_pc_out", pc_out, 16'h0091);
      chk("stall_instr", instr, 16'h0091 ^ 16'hA5A5);
      chk("stall_req_hold", {15'd0, imem_req}, 16'd0);
    end
    redirect_beq(16'h0200);
    step();
    clr_redirect();
    stall = 1'b0;
    imem_ready = 1'b0;
    chk("stall_redir_flush", {15'd0, flush_ifid}, 16'd1);
    chk("stall_redir_valid", {15'd0, instr_valid}, 16'd0);
    chk("stall_redir_addr", imem_addr, 16'h0200);

    // PC wrap FFFF -> 0000.
    redirect_beq(16'hFFFF);
    imem_ready = 1'b1;
    step();
    clr_redirect();
    imem_ready = 1'b0;
    chk("wrap_redir_addr", imem_addr, 16'hFFFF);
    run_seq(2, 16'hFFFF);
    chk("wrap_next_addr", imem_addr, 16'h0001);

    // Reset during a DROP wait.
    redirect_beq(16'h0300);
    step();
    clr_redirect();
    chk("drop_req", {15'd0, imem_req}, 16'd1);
    chk("drop_addr", imem_addr, 16'h0001);
    rst_n = 1'b0;
    step();
    chk("rstm_req", {15'd0, imem_req}, 16'd0);
    chk("rstm_valid", {15'd0, instr_valid}, 16'd0);
    chk("rstm_flush_ifid", {15'd0, flush_ifid}, 16'd0);
    chk("rstm_flush_idex", {15'd0, flush_idex}, 16'd0);
    chk("rstm_pc_out", pc_out, 16'h0000);
    rst_n = 1'b1;
    imem_ready = 1'b1;
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0001);
    step();
    chk("rel_addr", imem_addr, 16'h0000);
    chk("rel_req", {15'd0, imem_req}, 16'd1);
    chk("rel_valid", {15'd0, instr_valid}, 16'd0);
    step(); step();
    imem_ready = 1'b0;
    step();
    chk("sb_empty", 16'(exp_q.size()), 16'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
